// File: rtl/adder_arbiter.sv
// Round-robin share of one external 32-bit adder; result valid 2 edges after accept.
// A stalled result (rsp_ready low) holds the FSM in RESP and blocks all new grants.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           add_in1,
  output logic [31:0]           add_in2,
  input  logic [31:0]           add_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, winner, ptr_nxt;
  logic            found;
  logic [31:0]     sel_a, sel_b;
  logic [31:0]     op_a, op_b;

  // Two passes give the wrapped scan: indices at/above rr_ptr first, then below.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) < rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  assign ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  // Grant is gated by rst_n so reset clears req_ready immediately, not at the next edge.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = CALC;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (winner == ID_W'(i));
          end
        end
      end
      CALC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            rsp_id <= winner;
            rr_ptr <= ptr_nxt;
          end
        end
        CALC: begin
          rsp_data  <= add_out;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand registers only change on accept, so the adder is quiet outside CALC.
  assign add_in1 = op_a;
  assign add_in2 = op_b;

endmodule
